subtractor64_seq: RTL and testbench



---
 rtl/risk_v_alu_pkg.sv | 20 ++
 rtl/sub_slice16.sv | 20 ++
 rtl/subtractor64_seq.sv | 137 +++++++++++++
 tb/tb_subtractor64_seq.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/risk_v_alu_pkg.sv
// Shared definitions for the Risk_V ALU datapath blocks: FSM state
// encodings, default geometry of the sliced subtractor and a width helper.
package risk_v_alu_pkg;

  // Counter width for n slices; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefWidth = 64;
  localparam int unsigned DefSlice = 16;
  localparam int unsigned NSLICE   = DefWidth / DefSlice;
  localparam int unsigned CNT_W    = cnt_width(NSLICE);

  // FSM state encodings
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/sub_slice16.sv
// Combinational slice of the subtractor: a + ~b + cin, i.e. a - b with the
// carry-in acting as the inverted borrow.
module sub_slice16
  import risk_v_alu_pkg::*;
#(
  parameter int unsigned SLICE = DefSlice
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] sum_o,
  output logic             cout_o
);

  // Single SLICE-bit add with the subtrahend inverted
  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, ~b_i} + {{SLICE{1'b0}}, cin_i};
  end

endmodule

// File: rtl/subtractor64_seq.sv
// Multi-cycle subtractor: D = A - B - Bin, one SLICE-bit slice per clock with
// the inter-slice borrow kept (inverted, as a carry) in a register.
// Valid/ready handshake on both sides; result and flags held until taken.
module subtractor64_seq
  import risk_v_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SLICE = DefSlice
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Z,
  output logic             V
);

  localparam int unsigned NSlice  = WIDTH / SLICE;
  localparam int unsigned CntW    = cnt_width(NSlice);
  localparam logic [CntW-1:0] LastCnt = CntW'(NSlice - 1);

  if ((WIDTH % SLICE) != 0 || WIDTH == 0) begin : gen_bad_geometry
    $error("subtractor64_seq: WIDTH must be a non-zero multiple of SLICE");
  end

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             z_q, z_d;
  logic             v_q, v_d;

  logic [SLICE-1:0] a_k, b_k, sum_k;
  logic             cout_k;

  // Select the operand slice addressed by the counter
  always_comb begin
    a_k = a_q[cnt_q * SLICE +: SLICE];
    b_k = b_q[cnt_q * SLICE +: SLICE];
  end

  sub_slice16 #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i    (a_k),
    .b_i    (b_k),
    .cin_i  (carry_q),
    .sum_o  (sum_k),
    .cout_o (cout_k)
  );

  // FSM, slice sequencing and flag generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    d_d     = d_q;
    bout_d  = bout_q;
    z_d     = z_q;
    v_d     = v_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = ~Bin;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        d_d[cnt_q * SLICE +: SLICE] = sum_k;
        carry_d = cout_k;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          // d_d already holds the final slice here
          bout_d  = ~cout_k;
          z_d     = (d_d == '0);
          v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      z_q     <= z_d;
      v_q     <= v_d;
    end
  end

  // Outputs decoded from state and result registers
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    D         = d_q;
    Bout      = bout_q;
    Z         = z_q;
    V         = v_q;
  end

endmodule

// File: tb/tb_subtractor64_seq.sv
// Self-checking bench for subtractor64_seq: directed corner cases plus
// randomized back-to-back operations against a plain-arithmetic model.
module tb_subtractor64_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] A = '0;
  logic [63:0] B = '0;
  logic        Bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] D;
  logic        Bout, Z, V;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  subtractor64_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .Bout      (Bout),
    .Z         (Z),
    .V         (V)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One full transaction; noise toggles inputs that must be ignored.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bin,
                        input int hold, input bit noise);
    logic [64:0] full;
    logic [63:0] exp_d;
    logic [2:0]  exp_f;
    int          cyc;
    full  = {1'b0, a} - {1'b0, b} - {64'd0, bin};
    exp_d = full[63:0];
    exp_f = {full[64], exp_d == 64'd0, (a[63] != b[63]) && (exp_d[63] != a[63])};

    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = rnd64(); B = rnd64(); Bin = ~bin;
    check("in_ready_after_accept", 64'(in_ready), 64'd0);

    cyc = 0;
    while (!out_valid && cyc < 16) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        A = rnd64(); B = rnd64(); Bin = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("latency", 64'(cyc), 64'd4);
    check("out_valid_rise", 64'(out_valid), 64'd1);
    if (!out_valid) return;
    check("in_ready_done", 64'(in_ready), 64'd0);
    check("D", D, exp_d);
    check("flags_bzv", 64'({Bout, Z, V}), 64'(exp_f));

    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        A = rnd64(); B = rnd64();
      end
      @(negedge clk);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_D", D, exp_d);
      check("hold_flags", 64'({Bout, Z, V}), 64'(exp_f));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 64'(out_valid), 64'd0);
    check("in_ready_return", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] ra, rb;
    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_D", D, 64'd0);
    check("rst_flags", 64'({Bout, Z, V}), 64'd0);

    // Directed cases
    run_op(64'd5, 64'd3, 1'b0, 0, 1'b0);
    run_op(64'd0, 64'd1, 1'b0, 1, 1'b0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 0, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 0, 1'b0);
    run_op(64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 1'b0, 0, 1'b0);
    run_op(64'hDEAD_BEEF_0000_FFFF, 64'hDEAD_BEEF_0000_FFFF, 1'b0, 10, 1'b1);

    // Reset on the second CALC cycle aborts the operation
    @(negedge clk);
    A = 64'd77; B = 64'd5; Bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_D", D, 64'd0);
    check("abort_flags", 64'({Bout, Z, V}), 64'd0);
    repeat (5) begin
      @(negedge clk);
      check("abort_no_result", 64'(out_valid), 64'd0);
    end
    run_op(64'd10, 64'd20, 1'b0, 0, 1'b0);

    // Randomized back-to-back operations with stalls
    for (int n = 0; n < 60; n++) begin
      ra = rnd64();
      rb = ($urandom_range(0, 7) == 0) ? ra : rnd64();
      if ($urandom_range(0, 7) == 0) ra[63:16] = rb[63:16];
      run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
